// File: rtl/thermal_pkg.sv
// ----------------------------------------------------------------------------
// thermal_pkg: shared types and constants for the thermal-frame pipeline.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package thermal_pkg;

  localparam int DATAW    = 16;
  localparam int MAX_ADDR = 2**6 - 1;
  localparam int ADDRW    = $clog2(MAX_ADDR + 1);
  // Wide enough to count past the last read through the deepest read latency (4).
  localparam int CNTW     = $clog2(MAX_ADDR + 5);

  localparam logic [DATAW-1:0] c_pix_max = {1'b0, {(DATAW-1){1'b1}}};
  localparam logic [DATAW-1:0] c_pix_min = {1'b1, {(DATAW-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } t_scan_states;

  typedef struct packed {
    t_scan_states     state;
    logic [CNTW-1:0]  addr;
    logic [DATAW-1:0] run_min;
    logic [DATAW-1:0] run_max;
  } t_scan_regs;

  localparam t_scan_regs c_scan_regs_rst = '{
    state:   IDLE,
    addr:    '0,
    run_min: c_pix_max,
    run_max: c_pix_min
  };

endpackage

`default_nettype wire

// File: rtl/frame_minmax_scanner.sv
// ----------------------------------------------------------------------------
// frame_minmax_scanner: one pass over frame memory producing signed min and range.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module frame_minmax_scanner
  import thermal_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  output logic                    o_busy,
  output logic                    o_done,
  output logic signed [DATAW-1:0] o_min,
  output logic        [DATAW-1:0] o_range,
  output logic                    o_rd_valid,
  output logic        [ADDRW-1:0] o_rd_addr,
  input  logic signed [DATAW-1:0] i_rd_data
);

  localparam logic [CNTW-1:0] c_last_rd  = CNTW'(MAX_ADDR);
  localparam logic [CNTW-1:0] c_last_cnt = CNTW'(MAX_ADDR + RD_LATENCY);

  t_scan_regs              r_q, r_d;
  logic [RD_LATENCY-1:0]   vld_pipe_q;
  logic signed [DATAW-1:0] min_q, min_d;
  logic [DATAW-1:0]        range_q, range_d;
  logic signed [DATAW-1:0] w_run_min, w_run_max;
  logic                    w_rd_valid;
  logic                    w_sample;

  always_comb begin
    r_d        = r_q;
    min_d      = min_q;
    range_d    = range_q;
    w_rd_valid = (r_q.state == SCAN) && (r_q.addr <= c_last_rd);
    w_sample   = vld_pipe_q[RD_LATENCY-1];
    w_run_min  = $signed(r_q.run_min);
    w_run_max  = $signed(r_q.run_max);

    if (w_sample) begin
      if (i_rd_data < $signed(r_q.run_min)) w_run_min = i_rd_data;
      if (i_rd_data > $signed(r_q.run_max)) w_run_max = i_rd_data;
    end

    case (r_q.state)
      IDLE: begin
        r_d.addr    = '0;
        r_d.run_min = c_pix_max;
        r_d.run_max = c_pix_min;
        if (i_start) r_d.state = SCAN;
      end
      SCAN: begin
        r_d.run_min = w_run_min;
        r_d.run_max = w_run_max;
        if (r_q.addr == c_last_cnt) begin
          r_d.state = DONE;
          min_d     = w_run_min;
          // max >= min always, so the true difference fits DATAW bits unsigned
          // and a DATAW-bit subtract yields it exactly.
          range_d   = w_run_max - w_run_min;
        end else begin
          r_d.addr = r_q.addr + CNTW'(1);
        end
      end
      DONE: begin
        r_d.state = IDLE;
      end
      default: begin
        r_d = c_scan_regs_rst;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q        <= c_scan_regs_rst;
      vld_pipe_q <= '0;
      min_q      <= '0;
      range_q    <= '0;
    end else begin
      r_q           <= r_d;
      min_q         <= min_d;
      range_q       <= range_d;
      vld_pipe_q[0] <= w_rd_valid;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
      end
    end
  end

  assign o_busy     = (r_q.state != IDLE);
  assign o_done     = (r_q.state == DONE);
  assign o_min      = min_q;
  assign o_range    = range_q;
  assign o_rd_valid = w_rd_valid;
  assign o_rd_addr  = r_q.addr[ADDRW-1:0];

endmodule

`default_nettype wire

// File: tb/tb_frame_minmax_scanner.sv
// ----------------------------------------------------------------------------
// tb_frame_minmax_scanner: scoreboard bench for latency-1 and latency-3 scanners.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_frame_minmax_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic               rst1 = 1'b1, rst3 = 1'b1, start1 = 1'b0, start3 = 1'b0;
  logic               busy1, done1, rd_valid1, busy3, done3, rd_valid3;
  logic signed [15:0] min1, min3, rd_data1, rd_data3;
  logic        [15:0] range1, range3;
  logic        [5:0]  rd_addr1, rd_addr3;

  logic signed [15:0] mem [64];
  logic signed [15:0] p3 [3];

  frame_minmax_scanner #(.RD_LATENCY(1)) dut1 (
    .i_clk(clk), .i_rst(rst1), .i_start(start1), .o_busy(busy1), .o_done(done1),
    .o_min(min1), .o_range(range1), .o_rd_valid(rd_valid1), .o_rd_addr(rd_addr1),
    .i_rd_data(rd_data1)
  );

  frame_minmax_scanner #(.RD_LATENCY(3)) dut3 (
    .i_clk(clk), .i_rst(rst3), .i_start(start3), .o_busy(busy3), .o_done(done3),
    .o_min(min3), .o_range(range3), .o_rd_valid(rd_valid3), .o_rd_addr(rd_addr3),
    .i_rd_data(rd_data3)
  );

  // Memory models: data is garbage unless it answers a read issued LATENCY cycles ago.
  always @(posedge clk) rd_data1 <= rd_valid1 ? mem[rd_addr1] : 16'($urandom);
  always @(posedge clk) begin
    p3[0] <= rd_valid3 ? mem[rd_addr3] : 16'($urandom);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign rd_data3 = p3[2];

  typedef struct {
    logic [15:0] mn;
    logic [15:0] rg;
    int          t_done;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               tag, got, got, exp, exp, cyc);
    end
  endtask

  function automatic void expect_frame(output logic [15:0] mn, output logic [15:0] rg);
    int lo, hi;
    lo = 32767;
    hi = -32768;
    for (int k = 0; k < 64; k++) begin
      if (int'(mem[k]) < lo) lo = int'(mem[k]);
      if (int'(mem[k]) > hi) hi = int'(mem[k]);
    end
    mn = 16'(lo);
    rg = 16'(hi - lo);
  endfunction

  // Called on a negedge; the pulse is sampled at the next posedge.
  task automatic pulse_start(input bit d3, input bit accept);
    exp_t e;
    expect_frame(e.mn, e.rg);
    e.t_done = cyc + 2 + 63 + (d3 ? 3 : 1);
    if (d3) start3 = 1'b1;
    else    start1 = 1'b1;
    if (accept) begin
      if (d3) q3.push_back(e);
      else    q1.push_back(e);
    end
    @(negedge clk);
    start1 = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_drain(input bit d3);
    int n;
    n = 0;
    while (((d3 ? q3.size() : q1.size()) != 0) && (n < 300)) begin
      @(negedge clk);
      n++;
    end
    check(d3 ? "drain3" : "drain1", d3 ? q3.size() : q1.size(), 0);
    @(negedge clk);
  endtask

  initial begin : mon1
    exp_t e;
    int   rd;
    rd = 0;
    forever begin
      @(negedge clk);
      if (rst1) begin
        rd = 0;
      end else begin
        if (rd_valid1) begin
          check("rd_addr1", rd_addr1, rd);
          rd++;
        end
        if (done1) begin
          if (q1.size() == 0) begin
            check("unexpected_done1", done1, 0);
          end else begin
            e = q1.pop_front();
            check("min1", $unsigned(min1), e.mn);
            check("range1", range1, e.rg);
            check("done_cycle1", cyc, e.t_done);
            check("reads1", rd, 64);
          end
          rd = 0;
        end
      end
    end
  end

  initial begin : mon3
    exp_t e;
    int   rd;
    rd = 0;
    forever begin
      @(negedge clk);
      if (rst3) begin
        rd = 0;
      end else begin
        if (rd_valid3) begin
          check("rd_addr3", rd_addr3, rd);
          rd++;
        end
        if (done3) begin
          if (q3.size() == 0) begin
            check("unexpected_done3", done3, 0);
          end else begin
            e = q3.pop_front();
            check("min3", $unsigned(min3), e.mn);
            check("range3", range3, e.rg);
            check("done_cycle3", cyc, e.t_done);
            check("reads3", rd, 64);
          end
          rd = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t;
    repeat (3) @(negedge clk);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_rd_valid", rd_valid1, 0);
    check("rst_rd_addr", rd_addr1, 0);
    check("rst_min", $unsigned(min1), 0);
    check("rst_range", range1, 0);
    rst1 = 1'b0;
    rst3 = 1'b0;
    @(negedge clk);

    // Ramp: 10*k-100, plus first-read timing.
    for (int k = 0; k < 64; k++) mem[k] = 16'(10 * k - 100);
    pulse_start(0, 1);
    check("first_read_busy", busy1, 1);
    check("first_read_valid", rd_valid1, 1);
    wait_drain(0);

    // Constant frame.
    for (int k = 0; k < 64; k++) mem[k] = 16'sd250;
    pulse_start(0, 1);
    wait_drain(0);

    // Full-scale extremes: range must not wrap.
    for (int k = 0; k < 64; k++) mem[k] = 16'sd0;
    mem[5]  = 16'sh8000;
    mem[40] = 16'sh7FFF;
    pulse_start(0, 1);
    wait_drain(0);

    // Starts while busy are dropped; the first IDLE cycle accepts.
    for (int k = 0; k < 64; k++) mem[k] = 16'(3 * k - 7);
    t = cyc;
    pulse_start(0, 1);
    wait_until(t + 10);
    pulse_start(0, 0);
    wait_until(t + 66);
    pulse_start(0, 0);
    check("accept_cycle", cyc, t + 67);
    pulse_start(0, 1);
    wait_drain(0);

    // Reset mid-scan aborts without a done pulse.
    for (int k = 0; k < 64; k++) mem[k] = 16'(k * k - 1000);
    t = cyc;
    pulse_start(0, 1);
    wait_until(t + 20);
    rst1 = 1'b1;
    q1.delete();
    @(negedge clk);
    check("abort_busy", busy1, 0);
    check("abort_rd_valid", rd_valid1, 0);
    check("abort_done", done1, 0);
    check("abort_min", $unsigned(min1), 0);
    check("abort_range", range1, 0);
    @(negedge clk);
    rst1 = 1'b0;
    repeat (80) @(negedge clk);
    pulse_start(0, 1);
    wait_drain(0);

    // Latency-3 memory: descending data, then hold across the next scan.
    for (int k = 0; k < 64; k++) mem[k] = 16'(63 - k);
    pulse_start(1, 1);
    wait_drain(1);
    for (int k = 0; k < 64; k++) mem[k] = 16'(k - 5);
    t = cyc;
    pulse_start(1, 1);
    wait_until(t + 10);
    check("hold_min_10", $unsigned(min3), 0);
    check("hold_range_10", range3, 63);
    wait_until(t + 40);
    check("hold_min_40", $unsigned(min3), 0);
    check("hold_range_40", range3, 63);
    wait_until(t + 67);
    check("hold_busy_67", busy3, 1);
    check("hold_min_67", $unsigned(min3), 0);
    check("hold_range_67", range3, 63);
    wait_drain(1);

    repeat (5) @(negedge clk);
    check("final_q1_empty", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
